// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W_DEF   = 4;
    localparam int RPT_W_DEF   = 3;

endpackage

// File: rtl/seq_gen_shreg.sv
// Pattern store: rotates left within the low sel+1 bits so that after len
// shifts the original pattern is back in place for the next repetition.
module seq_gen_shreg #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               load,
    input  logic               shift,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   sel,
    output logic               next_bit
);

    localparam logic [MAX_LEN-1:0] ONES = {MAX_LEN{1'b1}};
    localparam logic [MAX_LEN-1:0] ONE  = MAX_LEN'(1);

    logic [MAX_LEN-1:0] q;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] pick;
    logic [MAX_LEN-1:0] rot;
    logic               cur;

    always_comb begin
        pick = ONE << sel;
        mask = ~((ONES << sel) << 1);
        cur  = |(q & pick);
        rot  = ({q[MAX_LEN-2:0], 1'b0} | {{(MAX_LEN-1){1'b0}}, cur}) & mask;
        // bit that sits at the selected MSB position after this edge
        next_bit = shift ? |(rot & pick) : cur;
    end

    always_ff @(posedge clk) begin
        if (load)
            q <= pattern;
        else if (shift)
            q <= rot;
    end

endmodule

// File: rtl/seq_gen.sv
// Serial bit-sequence generator, MSB-first, with optional repeats.
// Define SEQ_GEN_GAP_EN to insert one idle cycle between repetitions.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int RPT_W   = RPT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [RPT_W-1:0]   rpt,
    output logic               data_out,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam logic [MAX_LEN-1:0] ONE     = MAX_LEN'(1);
    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);

    state_t           state;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] sel;
    logic [RPT_W-1:0] pass;
    logic [LEN_W-1:0] len_c;
    logic             load;
    logic             shift;
    logic             first;
    logic             next_bit;

    always_comb begin
        len_c = (len > LEN_MAX) ? LEN_MAX : len;
        load  = (state == IDLE) && start && (len_c != '0);
        shift = (state == SHIFT);
        first = |(pattern & (ONE << (len_c - LEN_W'(1))));
    end

    seq_gen_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .load     (load),
        .shift    (shift),
        .pattern  (pattern),
        .sel      (sel),
        .next_bit (next_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            sel      <= '0;
            pass     <= '0;
            data_out <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pass <= rpt;
                        if (len_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= SHIFT;
                            idx      <= len_c - LEN_W'(1);
                            sel      <= len_c - LEN_W'(1);
                            valid    <= 1'b1;
                            busy     <= 1'b1;
                            data_out <= first;
                        end
                    end
                end
                SHIFT: begin
                    if (idx != '0) begin
                        idx      <= idx - LEN_W'(1);
                        data_out <= next_bit;
                    end else if (pass != '0) begin
                        pass <= pass - RPT_W'(1);
                        idx  <= sel;
`ifdef SEQ_GEN_GAP_EN
                        state    <= GAP;
                        valid    <= 1'b0;
                        data_out <= 1'b0;
`else
                        data_out <= next_bit;
`endif
                    end else begin
                        state    <= DONE;
                        valid    <= 1'b0;
                        data_out <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                GAP: begin
                    state    <= SHIFT;
                    valid    <= 1'b1;
                    data_out <= next_bit;
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen with a behavioural 101 detector on the line.
module tb_seq_gen;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int RPT_W   = 3;
`ifdef SEQ_GEN_GAP_EN
    localparam int GAPS = 1;
`else
    localparam int GAPS = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [MAX_LEN-1:0] pattern = '0;
    logic [LEN_W-1:0]   len = '0;
    logic [RPT_W-1:0]   rpt = '0;
    logic               data_out, valid, busy, done;

    int errors = 0;
    int checks = 0;
    int sb[$];

    logic [1:0] dstate;
    int det_pulses = 0;
    int det_bad    = 0;
    int det_pos    = -1;
    int vcount     = 0;

    always #5 clk = ~clk;

    seq_gen #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .RPT_W   (RPT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .rpt      (rpt),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    // Non-overlapping 101 Mealy detector: 0 idle, 1 saw "1", 2 saw "10".
    always @(posedge clk) begin
        if (!rst)
            dstate <= 2'd0;
        else case (dstate)
            2'd0:    dstate <= data_out ? 2'd1 : 2'd0;
            2'd1:    dstate <= data_out ? 2'd1 : 2'd2;
            default: dstate <= 2'd0;
        endcase
    end

    always @(negedge clk) begin
        if (valid) vcount++;
        if (dstate == 2'd2 && data_out) begin
            det_pulses++;
            if (!valid) det_bad++;
            det_pos = vcount;
        end
    end

    // Monitor: every valid bit or done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst && (valid || done)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: valid=%0b done=%0b data=%0b, expected no output",
                         valid, done, data_out);
            end else begin
                int exp;
                exp = sb.pop_front();
                if (exp == 2) begin
                    if (!(done && !valid && !busy)) begin
                        errors++;
                        $display("FAIL done_pulse: valid=%0b done=%0b busy=%0b, expected done only",
                                 valid, done, busy);
                    end
                end else if (!(valid && !done && busy && (int'(data_out) == exp))) begin
                    errors++;
                    $display("FAIL serial_bit: valid=%0b done=%0b busy=%0b data=%0b, expected data=%0d valid busy",
                             valid, done, busy, data_out, exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [7:0] pat, input logic [3:0] ln, input logic [2:0] rp,
                       input logic [7:0] expb, input int nb, input bit disturb);
        int c;
        int exp_cycles;
        for (int p = 0; p <= int'(rp); p++)
            for (int i = nb - 1; i >= 0; i--)
                sb.push_back(int'(expb[i]));
        sb.push_back(2);
        exp_cycles = nb * (int'(rp) + 1) + ((nb > 0) ? GAPS * int'(rp) : 0) + 1;
        @(negedge clk);
        pattern = pat;
        len     = ln;
        rpt     = rp;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        if (disturb) begin
            start   = 1'b1;
            pattern = ~pat;
            len     = 4'd1;
            rpt     = 3'd5;
        end
        while (!done && c < 64) begin
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check("done_latency", c, exp_cycles);
        @(negedge clk);
        check("idle_after_done", int'({valid, busy, done, data_out}), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({valid, busy, done, data_out}), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", int'({valid, busy, done, data_out}), 0);

        run(8'b101, 4'd3, 3'd0, 8'b101, 3, 1'b0);
        run(8'b101, 4'd3, 3'd1, 8'b101, 3, 1'b0);
        run(8'b0110, 4'd4, 3'd2, 8'b0110, 4, 1'b0);
        run(8'b1, 4'd1, 3'd2, 8'b1, 1, 1'b0);

        vcount = 0;
        run(8'hFF, 4'd0, 3'd0, 8'b0, 0, 1'b0);
        check("len0_no_valid", vcount, 0);

        run(8'b11001010, 4'd12, 3'd0, 8'b11001010, 8, 1'b0);
        run(8'b110, 4'd3, 3'd0, 8'b110, 3, 1'b1);

        // Abort during the second bit.
        @(negedge clk);
        pattern = 8'b101;
        len     = 4'd3;
        rpt     = 3'd0;
        start   = 1'b1;
        sb.push_back(1);
        sb.push_back(0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", int'({valid, busy, done, data_out}), 0);
        check("abort_state", int'(dut.state), 0);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        run(8'b101, 4'd3, 3'd0, 8'b101, 3, 1'b0);

        det_pulses = 0;
        det_bad    = 0;
        det_pos    = -1;
        vcount     = 0;
        run(8'b10101, 4'd5, 3'd0, 8'b10101, 5, 1'b0);
        repeat (3) @(negedge clk);
        check("det_pulses", det_pulses, 1);
        check("det_outside_valid", det_bad, 0);
        check("det_position", det_pos, 3);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
